// File: rtl/byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
//
// Byte-addressable RAM built on 32-bit words. It has one write port with
// byte-lane enables and one synchronous read port. Reads and writes can be
// byte, half-word or word sized. Read data is right-aligned and can be
// sign-extended or zero-extended. After reset, an optional clear sequence
// zeroes every word through the write port.
//
// Parameters
//   ADDR_WIDTH     : log2 of the memory depth in 32-bit words
//   CLEAR_ON_RESET : 1 = zero every word after reset, 0 = contents survive reset
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   wd       in  32  write data, right-aligned (byte [7:0], half [15:0])
//   wa       in  32  byte write address
//   we       in   1  write enable
//   wsize    in   2  write size: 00 byte, 01 half, 10 word, 11 invalid
//   ra       in  32  byte read address (a read happens every cycle)
//   rsize    in   2  read size, same encoding as wsize
//   rsigned  in   1  1 = sign-extend byte/half reads, 0 = zero-extend
//   out      out 32  read data, one cycle after ra/rsize/rsigned are sampled
//   busy     out  1  clear sequence running; accesses are ignored
//   misalign out  1  one-cycle pulse: the previous cycle had an illegal access
// -----------------------------------------------------------------------------
module byte_ram #(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wd,
    input  logic [31:0] wa,
    input  logic        we,
    input  logic [1:0]  wsize,
    input  logic [31:0] ra,
    input  logic [1:0]  rsize,
    input  logic        rsigned,
    output logic [31:0] out,
    output logic        busy,
    output logic        misalign
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // ------------------------------------------------------------------------
    // Access helpers
    // ------------------------------------------------------------------------

    // Legality depends on the two lane-offset bits only. The upper address
    // bits wrap and are never checked.
    function automatic logic size_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian lane enables for a write of the given size and offset.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // The narrow write data is replicated across the word. The lane enables
    // then pick which copy lands in memory, so no shifter is needed.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        d = data;
        case (size)
            SZ_BYTE: d = {4{data[7:0]}};
            SZ_HALF: d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [1:0]            w_off;
    logic [1:0]            r_off;
    logic                  w_legal;
    logic                  r_legal;

    assign w_idx   = wa[ADDR_WIDTH+1:2];
    assign r_idx   = ra[ADDR_WIDTH+1:2];
    assign w_off   = wa[1:0];
    assign r_off   = ra[1:0];
    assign w_legal = size_legal(wsize, w_off);
    assign r_legal = size_legal(rsize, r_off);

    // The address bits above the word index wrap and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wa[31:ADDR_WIDTH+2], ra[31:ADDR_WIDTH+2]};

    // ------------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------------
    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // Terminal until the next reset.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // ------------------------------------------------------------------------
    // Write port mux: the clear sequence and user writes share one port
    // ------------------------------------------------------------------------
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = cnt_q;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (!rst) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_idx   = cnt_q;
                mem_be    = 4'b1111;
                mem_wdata = '0;
            end else if (we && w_legal) begin
                mem_we    = 1'b1;
                mem_idx   = w_idx;
                mem_be    = lane_enables(wsize, w_off);
                mem_wdata = lane_data(wsize, wd);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: one write port with lane enables, one registered read port
    // ------------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;

    // NOTE: the array and its read register have no reset, so the tools can
    // map them to block RAM. Zeroing is done by the clear FSM instead.
    // Because the read and the write share one non-blocking update, a
    // same-word access in one cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
        rd_word <= mem[r_idx];
    end

    // ------------------------------------------------------------------------
    // Read-side control pipeline (resettable, alongside the RAM output)
    // ------------------------------------------------------------------------
    logic       rvalid_q;
    logic [1:0] rsize_q;
    logic [1:0] roff_q;
    logic       rsigned_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q  <= 1'b0;
            rsize_q   <= SZ_WORD;
            roff_q    <= 2'b00;
            rsigned_q <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            rvalid_q  <= ~busy & r_legal;
            rsize_q   <= rsize;
            roff_q    <= r_off;
            rsigned_q <= rsigned;
            misalign  <= ~busy & ((we & ~w_legal) | ~r_legal);
        end
    end

    // Lane select and extension after the RAM register. out depends only on
    // registers, so it changes only at clock edges, one cycle after sampling.
    logic [31:0] shifted;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        shifted = rd_word >> {roff_q, 3'b000};
        lane8   = shifted[7:0];
        lane16  = shifted[15:0];
        out     = '0;
        if (rvalid_q) begin
            case (rsize_q)
                SZ_BYTE: out = {{24{rsigned_q & lane8[7]}}, lane8};
                SZ_HALF: out = {{16{rsigned_q & lane16[15]}}, lane16};
                SZ_WORD: out = rd_word;
                default: out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_ram.sv
// -----------------------------------------------------------------------------
// tb_byte_ram
//
// Directed bench for byte_ram with ADDR_WIDTH=4. A second instance with
// CLEAR_ON_RESET=0 shares the access inputs and has its own reset, so that
// retention of memory contents across reset can be observed. The expected
// read results are queued when a cycle is driven and compared after the
// clock edge that produces them.
// -----------------------------------------------------------------------------
module tb_byte_ram;

    localparam int AW = 4;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_nc = 1'b1;
    logic [31:0] wd = '0;
    logic [31:0] wa = '0;
    logic        we = 1'b0;
    logic [1:0]  wsize = SZ_W;
    logic [31:0] ra = '0;
    logic [1:0]  rsize = SZ_W;
    logic        rsigned = 1'b0;
    logic [31:0] out;
    logic        busy;
    logic        misalign;
    logic [31:0] out_nc;
    logic        busy_nc;
    logic        misalign_nc;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_out_q[$];
    logic        exp_mis_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    byte_ram #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .wd(wd), .wa(wa), .we(we), .wsize(wsize),
        .ra(ra), .rsize(rsize), .rsigned(rsigned),
        .out(out), .busy(busy), .misalign(misalign)
    );

    byte_ram #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) dut_nc (
        .clk(clk), .rst(rst_nc), .wd(wd), .wa(wa), .we(we), .wsize(wsize),
        .ra(ra), .rsize(rsize), .rsigned(rsigned),
        .out(out_nc), .busy(busy_nc), .misalign(misalign_nc)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of access inputs and queue the read result it should
    // produce. After the edge, pop the expectation and compare it with the
    // registered outputs.
    task automatic step(input logic w_en, input logic [1:0] ws, input logic [31:0] waddr,
                        input logic [31:0] wdata, input logic [31:0] raddr,
                        input logic [1:0] rs, input logic rsg,
                        input logic [31:0] e_out, input logic e_mis, input string tag);
        logic [31:0] eo;
        logic        em;
        string       t;
        we = w_en; wsize = ws; wa = waddr; wd = wdata;
        ra = raddr; rsize = rs; rsigned = rsg;
        exp_out_q.push_back(e_out);
        exp_mis_q.push_back(e_mis);
        tag_q.push_back(tag);
        tick();
        we = 1'b0;
        eo = exp_out_q.pop_front();
        em = exp_mis_q.pop_front();
        t  = tag_q.pop_front();
        check(out, eo, {t, ".out"});
        check({31'b0, misalign}, {31'b0, em}, {t, ".misalign"});
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // ---------------- Reset and initial clear ----------------
        tick();
        tick();
        check({31'b0, busy}, 32'd1, "rst.busy");
        check(out, 32'd0, "rst.out");
        check({31'b0, misalign}, 32'd0, "rst.misalign");
        check({31'b0, busy_nc}, 32'd0, "rst_nc.busy");
        rst = 1'b0;
        rst_nc = 1'b0;

        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(n, 32'd16, "clear.cycles");

        for (int i = 0; i < 16; i++) begin
            step(0, SZ_W, 0, 0, i * 4, SZ_W, 0, 32'h0, 0, $sformatf("clear.rd%0d", i));
        end

        // ---------------- Byte lanes ----------------
        step(1, SZ_W, 32'h8, 32'h11223344, 32'h0, SZ_W, 0, 32'h0,        0, "lane.wword");
        step(1, SZ_B, 32'hA, 32'h000000AA, 32'h8, SZ_W, 0, 32'h11223344, 0, "lane.wbyte");
        step(1, SZ_H, 32'h8, 32'h0000BEEF, 32'h8, SZ_W, 0, 32'h11AA3344, 0, "lane.whalf");
        step(0, SZ_W, 32'h0, 32'h0,        32'h8, SZ_W, 0, 32'h11AABEEF, 0, "lane.result");

        // ---------------- Extension ----------------
        step(0, SZ_W, 0, 0, 32'hA, SZ_B, 1, 32'hFFFFFFAA, 0, "ext.byte_s");
        step(0, SZ_W, 0, 0, 32'hA, SZ_B, 0, 32'h000000AA, 0, "ext.byte_u");
        step(0, SZ_W, 0, 0, 32'h8, SZ_H, 1, 32'hFFFFBEEF, 0, "ext.half_s");
        step(0, SZ_W, 0, 0, 32'hA, SZ_H, 1, 32'h000011AA, 0, "ext.half_hi_s");
        step(0, SZ_W, 0, 0, 32'hB, SZ_B, 1, 32'h00000011, 0, "ext.byte3_s");
        step(0, SZ_W, 0, 0, 32'h9, SZ_B, 1, 32'hFFFFFFBE, 0, "ext.byte1_s");

        // ---------------- Misalignment ----------------
        step(1, SZ_W, 32'h5, 32'hDEADBEEF, 32'h8, SZ_W, 0, 32'h11AABEEF, 1, "mis.wword");
        step(0, SZ_W, 32'h0, 32'h0,        32'h4, SZ_W, 0, 32'h0,        0, "mis.unchanged");
        step(0, SZ_W, 32'h0, 32'h0,        32'h3, SZ_H, 0, 32'h0,        1, "mis.rhalf");
        step(0, SZ_W, 32'h0, 32'h0,        32'h7, SZ_B, 0, 32'h0,        0, "mis.pulse_end");
        step(1, SZ_X, 32'h8, 32'hFFFFFFFF, 32'h8, SZ_W, 0, 32'h11AABEEF, 1, "mis.wsize11");
        step(0, SZ_W, 32'h0, 32'h0,        32'h8, SZ_W, 0, 32'h11AABEEF, 0, "mis.wsize11_nowr");
        step(0, SZ_W, 32'h0, 32'h0,        32'h8, SZ_X, 0, 32'h0,        1, "mis.rsize11");
        step(0, SZ_X, 32'h0, 32'h0,        32'h8, SZ_W, 0, 32'h11AABEEF, 0, "mis.we0_ignored");
        step(1, SZ_H, 32'h6, 32'h00001234, 32'h4, SZ_W, 0, 32'h0,        0, "lane.whalf_hi");
        step(1, SZ_H, 32'h1, 32'h0000FFFF, 32'h4, SZ_W, 0, 32'h12340000, 1, "mis.whalf_odd");
        step(0, SZ_W, 32'h0, 32'h0,        32'h4, SZ_W, 0, 32'h12340000, 0, "mis.whalf_nowr");

        // ---------------- Read-before-write and wrap ----------------
        step(1, SZ_W, 32'h0,  32'h1, 32'h0,        SZ_W, 0, 32'h0,        0, "rbw.init");
        step(1, SZ_W, 32'h40, 32'h2, 32'h0,        SZ_W, 0, 32'h1,        0, "rbw.old");
        step(0, SZ_W, 32'h0,  32'h0, 32'h0,        SZ_W, 0, 32'h2,        0, "rbw.new");
        step(0, SZ_W, 32'h0,  32'h0, 32'h40,       SZ_W, 0, 32'h2,        0, "wrap.rd40");
        step(0, SZ_W, 32'h0,  32'h0, 32'hFFFFFF48, SZ_W, 0, 32'h11AABEEF, 0, "wrap.rdhigh");

        // ---------------- Reset mid-clear ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, SZ_W, 0, 0, 32'h3, SZ_H, 0, 32'h0, 0, $sformatf("busy.mask%0d", i));
        end
        rst = 1'b1;
        tick();
        check({31'b0, busy}, 32'd1, "midrst.busy");
        rst = 1'b0;

        // While the clear restarts, try a write to word 0 and an illegal read.
        // Both must be ignored: out stays 0 and misalign stays low.
        we = 1'b1; wsize = SZ_W; wa = 32'h0; wd = 32'hCAFEF00D;
        ra = 32'h3; rsize = SZ_H; rsigned = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
            check(out, 32'd0, "midrst.out_busy");
            check({31'b0, misalign}, 32'd0, "midrst.mis_busy");
        end
        we = 1'b0;
        check(n, 32'd16, "midrst.cycles");

        step(0, SZ_W, 0, 0, 32'h0, SZ_W, 0, 32'h0, 0, "midrst.word0");
        step(0, SZ_W, 0, 0, 32'h4, SZ_W, 0, 32'h0, 0, "midrst.word1");
        step(0, SZ_W, 0, 0, 32'h8, SZ_W, 0, 32'h0, 0, "midrst.word2");

        // ---------------- Retention with CLEAR_ON_RESET=0 ----------------
        // The no-clear instance received every write: word 2 = 0x11AABEEF,
        // and word 0 last got 0xCAFEF00D while the other instance was busy.
        rst_nc = 1'b1;
        tick();
        tick();
        check({31'b0, busy_nc}, 32'd0, "nc.busy");
        check(out_nc, 32'd0, "nc.rst_out");
        rst_nc = 1'b0;
        ra = 32'h8; rsize = SZ_W; rsigned = 1'b0;
        tick();
        check(out_nc, 32'h11AABEEF, "nc.word2");
        ra = 32'h0;
        tick();
        check(out_nc, 32'hCAFEF00D, "nc.word0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_ram.md
BYTE_RAM -- requirements
Module: byte_ram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning log2 of the memory depth in 32-bit words.
REQ-002 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 = zero every word after reset, 0 = contents untouched by reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wd, input, 32 bits: write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-006 The block SHALL have port wa, input, 32 bits: byte write address.
REQ-007 The block SHALL have port we, input, 1 bit: write enable.
REQ-008 The block SHALL have port wsize, input, 2 bits: write size, 00 byte, 01 half, 10 word, 11 invalid.
REQ-009 The block SHALL have port ra, input, 32 bits: byte read address; a read is performed every cycle.
REQ-010 The block SHALL have port rsize, input, 2 bits: read size, same encoding as wsize.
REQ-011 The block SHALL have port rsigned, input, 1 bit: 1 = sign-extend byte/half reads, 0 = zero-extend.
REQ-012 The block SHALL have port out, output, 32 bits: registered read data, right-aligned and extended.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the clear sequence runs; accesses are ignored while high.
REQ-014 The block SHALL have port misalign, output, 1 bit: registered one-cycle pulse flagging an illegal access in the previous cycle.

Function
REQ-015 Word index SHALL be addr[ADDR_WIDTH+1:2]; address bits above are ignored, so accesses wrap modulo 4*2^ADDR_WIDTH bytes.
REQ-016 Write legality: byte always legal; half legal iff wa[0]=0; word legal iff wa[1:0]=00; wsize=11 always illegal.
REQ-017 A legal write with we=1 and busy=0 SHALL update only the addressed lanes at the clock edge (byte: lane wa[1:0]; half: lanes wa[1]*2 and wa[1]*2+1; word: all four), little-endian (lane 0 = bits [7:0]); other lanes keep their value.
REQ-018 An illegal write SHALL leave memory unchanged.
REQ-019 Read latency SHALL be exactly one cycle: out at edge N+1 reflects ra/rsize/rsigned sampled at edge N.
REQ-020 Read data SHALL be the addressed lane(s) per the rules of REQ-016/REQ-017 applied to ra/rsize, placed in out[7:0] or out[15:0], upper bits filled with the MSB of the read data when rsigned=1, else zero.
REQ-021 A read of an illegal ra/rsize combination SHALL produce out=0.
REQ-022 Same-word read and write in one cycle SHALL be read-before-write: out shows the pre-write contents; new data is visible from the next read.
REQ-023 misalign SHALL be 1 in cycle N+1 iff in cycle N busy=0 and either (we=1 and the write was illegal) or the read was illegal; otherwise 0.
REQ-024 Clear FSM states SHALL be CLEAR and IDLE, with a clear counter of ADDR_WIDTH bits.
REQ-025 In CLEAR, each cycle with rst=0 SHALL write 0 to word[counter] and increment the counter; after word 2^ADDR_WIDTH-1 is written the FSM SHALL enter IDLE, taking exactly 2^ADDR_WIDTH cycles.
REQ-026 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-027 While busy=1, we SHALL be ignored, out SHALL be 0 and misalign SHALL be 0.
REQ-028 IDLE SHALL be terminal until the next rst.
REQ-029 Memory SHALL map to inferred block RAM: a single synchronous read port and a single write port with byte-lane enables, where the clear sequence uses the write port.

Reset
REQ-030 While rst=1, at each edge: out<=0, misalign<=0, counter<=0, state<=CLEAR if CLEAR_ON_RESET=1 else IDLE, busy<=CLEAR_ON_RESET.
REQ-031 While rst=1, no memory write SHALL occur.
REQ-032 rst asserted mid-clear SHALL restart the clear from word 0.
REQ-033 With CLEAR_ON_RESET=0, memory contents SHALL survive reset.
REQ-034 Without reset, the FSM state SHALL be undefined; a reset is required before use.

Verification
REQ-035 Reset clear: ADDR_WIDTH=4, hold rst for 2 cycles, then release -> busy=1 for exactly 16 cycles then 0; reading all 16 words returns 0.
REQ-036 Byte lanes: write word 0x11223344 @0x8, then byte 0xAA @0xA, then half 0xBEEF @0x8 -> word read @0x8 returns 0x11AABEEF.
REQ-037 Extension: with 0x11AABEEF @0x8, read byte @0xA with rsigned=1 -> 0xFFFFFFAA; with rsigned=0 -> 0x000000AA; half @0x8 signed -> 0xFFFFBEEF.
REQ-038 Misalign: word write 0xDEADBEEF @0x5 -> memory unchanged and misalign=1 for one cycle; half read @0x3 -> out=0 and misalign=1.
REQ-039 Read-before-write and wrap: ADDR_WIDTH=4, word @0x0 holds 0x1; write 0x2 @0x40 while reading @0x0 -> out=0x1; next read @0x0 -> 0x2.
REQ-040 Reset mid-clear: assert rst at clear cycle 5 for 1 cycle -> busy stays 1 for a full 16 cycles after release.
